// File: rtl/layer_sequencer_if.sv
// Bundle of run-control and engine-facing signals for layer_sequencer.
// The master side is the sequencer; the slave side is whoever drives start and eng_ready.
interface layer_sequencer_if #(
  parameter int LW = 2,
  parameter int CW = 4
);
  logic          start;
  logic          eng_ready;
  logic          eng_start;
  logic          eng_rst;
  logic          in_sel;
  logic [LW-1:0] w_sel;
  logic          write;
  logic          write_loc;
  logic          sample_valid;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          timeout_err;

  modport master (
    input  start, eng_ready,
    output eng_start, eng_rst, in_sel, w_sel, write, write_loc,
           sample_valid, count, busy, done, timeout_err
  );

  modport slave (
    output start, eng_ready,
    input  eng_start, eng_rst, in_sel, w_sel, write, write_loc,
           sample_valid, count, busy, done, timeout_err
  );
endinterface

// File: rtl/layer_sequencer.sv
// Steps a shared layer engine through NUM_LAYERS layers for each of NUM_SAMPLES samples,
// with start/busy/done handshake, per-sample strobe and a watchdog on each engine wait.
module layer_sequencer #(
  parameter int NUM_LAYERS  = 3,
  parameter int NUM_SAMPLES = 8,
  parameter int TIMEOUT     = 1024,
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int CW = $clog2(NUM_SAMPLES + 1),
  localparam int TW = (TIMEOUT > 0 && $clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1
) (
  input logic clk,
  input logic rst,
  layer_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FIRE  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam bit            WD_ON      = (TIMEOUT != 0);
  localparam logic [TW-1:0] TMAX       = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_SAMPLES);

  logic [2:0]    state, state_n;
  logic [LW-1:0] layer, layer_n;
  logic [CW-1:0] count, count_n;
  logic [TW-1:0] timer, timer_n;
  logic          err, err_n;

  logic [LW-1:0] w_sel_q;
  logic          in_sel_q;
  logic          write_loc_q;

  always_comb begin
    state_n = state;
    layer_n = layer;
    count_n = count;
    timer_n = timer;
    err_n   = err;
    case (state)
      S_IDLE, S_ERR: begin
        if (bus.start) begin
          state_n = S_CLEAR;
          layer_n = '0;
          count_n = '0;
          err_n   = 1'b0;
        end
      end
      S_CLEAR: state_n = S_FIRE;
      S_FIRE: begin
        state_n = S_WAIT;
        timer_n = '0;
      end
      S_WAIT: begin
        // A ready arriving on the very last allowed cycle still wins over the watchdog.
        if (bus.eng_ready) begin
          state_n = S_WRITE;
        end else if (WD_ON && timer == TMAX) begin
          state_n = S_ERR;
          err_n   = 1'b1;
        end else if (timer != '1) begin
          timer_n = timer + 1'b1;
        end
      end
      S_WRITE: begin
        if (layer != LAST_LAYER) begin
          layer_n = layer + 1'b1;
          state_n = S_CLEAR;
        end else begin
          layer_n = '0;
          count_n = count + 1'b1;
          state_n = (count_n == LAST_COUNT) ? S_DONE : S_CLEAR;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      layer <= '0;
      count <= '0;
      timer <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      layer <= layer_n;
      count <= count_n;
      timer <= timer_n;
      err   <= err_n;
    end
  end

  // Datapath selects are captured on entry to CLEAR so they hold through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_sel_q     <= '0;
      in_sel_q    <= 1'b0;
      write_loc_q <= 1'b0;
    end else if (state_n == S_CLEAR) begin
      w_sel_q     <= layer_n;
      in_sel_q    <= (layer_n != '0);
      write_loc_q <= layer_n[0];
    end
  end

  assign bus.eng_rst      = (state == S_CLEAR);
  assign bus.eng_start    = (state == S_FIRE);
  assign bus.write        = (state == S_WRITE);
  assign bus.sample_valid = (state == S_WRITE) && (layer == LAST_LAYER);
  assign bus.done         = (state == S_DONE);
  assign bus.busy         = (state != S_IDLE) && (state != S_ERR);
  assign bus.timeout_err  = err;
  assign bus.count        = count;
  assign bus.w_sel        = w_sel_q;
  assign bus.in_sel       = in_sel_q;
  assign bus.write_loc    = write_loc_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: 3 layers, 2 samples, 48-cycle watchdog.
module tb_layer_sequencer;
  localparam int NL = 3;
  localparam int NS = 2;
  localparam int TO = 48;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;
  localparam int CW = $clog2(NS + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  layer_sequencer_if #(.LW(LW), .CW(CW)) bus ();

  layer_sequencer #(.NUM_LAYERS(NL), .NUM_SAMPLES(NS), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s_rst, input logic s_start, input logic s_ready);
    rst           = s_rst;
    bus.start     = s_start;
    bus.eng_ready = s_ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic e_rst, input logic e_start,
                            input logic e_write, input logic e_sv, input logic e_busy,
                            input logic e_done, input logic e_err, input int e_count);
    checkOutput({tag, " eng_rst"},      32'(bus.eng_rst),      32'(e_rst));
    checkOutput({tag, " eng_start"},    32'(bus.eng_start),    32'(e_start));
    checkOutput({tag, " write"},        32'(bus.write),        32'(e_write));
    checkOutput({tag, " sample_valid"}, 32'(bus.sample_valid), 32'(e_sv));
    checkOutput({tag, " busy"},         32'(bus.busy),         32'(e_busy));
    checkOutput({tag, " done"},         32'(bus.done),         32'(e_done));
    checkOutput({tag, " timeout_err"},  32'(bus.timeout_err),  32'(e_err));
    checkOutput({tag, " count"},        32'(bus.count),        32'(e_count));
  endtask

  task automatic checkSel(input string tag, input int e_layer);
    checkOutput({tag, " w_sel"},     32'(bus.w_sel),     32'(e_layer));
    checkOutput({tag, " in_sel"},    32'(bus.in_sel),    32'(e_layer != 0));
    checkOutput({tag, " write_loc"}, 32'(bus.write_loc), 32'(e_layer % 2));
  endtask

  task automatic waitDone(input string tag, input int bound);
    int n = 0;
    while (bus.done !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    checkOutput({tag, " done seen"}, 32'(bus.done), 32'd1);
  endtask

  // Full run with eng_ready held high: every layer takes exactly CLEAR, FIRE, WAIT, WRITE.
  task automatic runClean(input string tag);
    applyStimulus(1'b1, 1'b1, 1'b1);
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      string t;
      int ph, ly;
      t = $sformatf("%s c%0d", tag, c);
      if (c <= 24) begin
        ph = (c - 1) % 4;
        ly = ((c - 1) / 4) % NL;
        checkState(t, ph == 0, ph == 1, ph == 3, (ph == 3) && (ly == NL - 1),
                   1'b1, 1'b0, 1'b0, (c - 1) / 12);
        checkSel(t, ly);
      end else if (c == 25) begin
        checkState(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        checkSel(t, 2);
      end else begin
        checkState(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        checkSel(t, 2);
      end
      step();
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();
    step();
    checkState("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    checkSel("reset", 0);
    rst = 1'b1;
    step();
    checkState("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    runClean("run1");

    // Layer 1 engine answers 37 cycles after its start pulse.
    applyStimulus(1'b1, 1'b1, 1'b1);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checkOutput("slow c4 write", 32'(bus.write), 32'd1);
    bus.eng_ready = 1'b0;
    step();
    step();
    checkOutput("slow c6 eng_start", 32'(bus.eng_start), 32'd1);
    checkOutput("slow c6 w_sel", 32'(bus.w_sel), 32'd1);
    for (int c = 7; c <= 42; c++) begin
      step();
      checkOutput($sformatf("slow c%0d eng_start", c), 32'(bus.eng_start), 32'd0);
      checkOutput($sformatf("slow c%0d write", c), 32'(bus.write), 32'd0);
    end
    step();
    bus.eng_ready = 1'b1;
    checkOutput("slow c43 write", 32'(bus.write), 32'd0);
    checkOutput("slow c43 busy", 32'(bus.busy), 32'd1);
    step();
    checkOutput("slow c44 write", 32'(bus.write), 32'd1);
    checkSel("slow c44", 1);
    checkOutput("slow c44 timeout_err", 32'(bus.timeout_err), 32'd0);
    waitDone("slow", 40);
    checkOutput("slow count", 32'(bus.count), 32'd2);
    checkOutput("slow timeout_err", 32'(bus.timeout_err), 32'd0);
    step();

    // Watchdog fires on sample 1 layer 0; count stays frozen at 1 in ERR.
    applyStimulus(1'b1, 1'b1, 1'b1);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 11; i++) step();
    checkOutput("wd c12 sample_valid", 32'(bus.sample_valid), 32'd1);
    bus.eng_ready = 1'b0;
    for (int i = 0; i < 50; i++) step();
    checkState("wd c62", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    step();
    checkState("wd c63", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    checkSel("wd c63", 0);
    bus.eng_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checkState("wd hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checkState("wd restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    waitDone("wd restart", 40);
    checkOutput("wd restart count", 32'(bus.count), 32'd2);
    step();

    // Ready arrives in the same cycle the timer hits TIMEOUT-1.
    applyStimulus(1'b1, 1'b1, 1'b0);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 49; i++) step();
    bus.eng_ready = 1'b1;
    checkState("edge c50", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    step();
    checkState("edge c51", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    waitDone("edge", 40);
    checkOutput("edge timeout_err", 32'(bus.timeout_err), 32'd0);
    step();

    // Stray start and eng_ready during CLEAR/FIRE must not disturb the run.
    applyStimulus(1'b1, 1'b1, 1'b0);
    step();
    checkOutput("stray c1 eng_rst", 32'(bus.eng_rst), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    step();
    checkState("stray c2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkState("stray c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    step();
    checkState("stray c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    step();
    checkOutput("stray c5 write", 32'(bus.write), 32'd1);
    checkSel("stray c5", 0);
    waitDone("stray", 40);
    checkOutput("stray count", 32'(bus.count), 32'd2);
    step();

    // Reset while waiting on sample 1 layer 2.
    applyStimulus(1'b1, 1'b1, 1'b1);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 21; i++) step();
    checkOutput("abort c22 eng_start", 32'(bus.eng_start), 32'd1);
    checkSel("abort c22", 2);
    checkOutput("abort c22 count", 32'(bus.count), 32'd1);
    bus.eng_ready = 1'b0;
    step();
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();
    checkState("abort reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    checkSel("abort reset", 0);
    step();
    checkOutput("abort no done", 32'(bus.done), 32'd0);
    rst = 1'b1;
    step();
    runClean("post-abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Parametrised successor of the fixed three-layer network controller.
- Steps a shared neuron/layer engine through NUM_LAYERS layers for each of NUM_SAMPLES input samples.
- Per layer it runs: clear engine, pulse start, wait for engine ready, write result into a ping-pong buffer.
- Adds start/busy/done handshake, per-sample valid strobe, programmable watchdog timeout with sticky error, and fully synchronous operation (no delay-based pulses).

Parameters:
NUM_LAYERS, 3, layers per sample (>=1)
NUM_SAMPLES, 8, samples per run (>=1)
TIMEOUT, 1024, max WAIT cycles per layer before error; 0 disables watchdog
LW, max(1,$clog2(NUM_LAYERS)), layer index width (derived)
CW, $clog2(NUM_SAMPLES+1), sample counter width (derived)
TW, max(1,$clog2(TIMEOUT+1)), watchdog counter width (derived)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
start  in  1  run request, sampled in IDLE or ERR only
eng_ready  in  1  engine result ready, honoured only in WAIT
eng_start  out  1  one-cycle engine start pulse
eng_rst  out  1  one-cycle engine clear pulse
in_sel  out  1  0 = external sample input, 1 = previous-layer buffer
w_sel  out  LW  weight bank select = current layer index
write  out  1  one-cycle buffer write strobe
write_loc  out  1  destination buffer = layer index bit 0
sample_valid  out  1  one-cycle pulse when last layer of a sample is written
count  out  CW  completed samples in current run
busy  out  1  high in every state except IDLE and ERR
done  out  1  one-cycle pulse at run completion
timeout_err  out  1  sticky watchdog error flag

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, layer=0, count=0, timer=0. All outputs are 0.
- Outputs are Moore outputs decoded from registered state and layer. in_sel, w_sel and write_loc are valid from CLEAR through WRITE and hold their last value in IDLE.
- IDLE: if start=1, then layer<=0, count<=0, timeout_err<=0, go to CLEAR.
- CLEAR: eng_rst=1 for 1 cycle, then go to FIRE.
- FIRE: eng_start=1 for 1 cycle, timer<=0, then go to WAIT.
- WAIT:
  - If eng_ready=1, go to WRITE (eng_ready takes priority over timeout in the same cycle).
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1, go to ERR.
  - Else timer<=timer+1.
- WRITE: write=1 for 1 cycle, write_loc=layer[0].
  - If layer<NUM_LAYERS-1: layer<=layer+1, go to CLEAR.
  - Else: sample_valid=1 this cycle, count<=count+1, layer<=0. If count+1==NUM_SAMPLES go to DONE, else go to CLEAR.
- DONE: done=1 for 1 cycle, go to IDLE. count holds NUM_SAMPLES until the next start.
- ERR: timeout_err=1 (held), busy=0, count and layer frozen. start=1 behaves as in IDLE (clears the error, restarts at sample 0). Otherwise stay in ERR.
- in_sel=0 when layer==0, else 1.
- Minimum per-layer latency, with eng_ready high in the first WAIT cycle: 4 cycles (CLEAR, FIRE, WAIT, WRITE).
  - Sample latency = 4*NUM_LAYERS cycles.
  - Run latency = 4*NUM_LAYERS*NUM_SAMPLES + 1 cycles from the first CLEAR to done.
- start while busy is ignored. eng_ready outside WAIT is ignored and not remembered.
- NUM_LAYERS=1: layer stays 0; every WRITE is a last-layer write with write_loc=0.
- Reset mid-run: abort on the same edge; return to IDLE, outputs 0, no done pulse.
- Counters never wrap: count maxes at NUM_SAMPLES and the timer at TIMEOUT-1.

Test Plan:
- NUM_LAYERS=3, NUM_SAMPLES=2, eng_ready returned 1 cycle after each eng_start -> w_sel sequence 0,1,2,0,1,2 and write_loc 0,1,0,0,1,0. in_sel=0 only for layer 0. sample_valid pulses at cycles 12 and 24 after the first CLEAR. count 0->1->2. done pulses at cycle 25, then busy=0.
- Engine delays eng_ready by 37 cycles on layer 1, TIMEOUT=1024 -> sequencer holds in WAIT with eng_start low; write occurs 1 cycle after eng_ready; no error.
- TIMEOUT=16, eng_ready never asserted -> after 16 WAIT cycles timeout_err=1 and busy=0. A following start clears timeout_err and restarts with count=0.
- eng_ready asserted in the same cycle the timer reaches TIMEOUT-1 -> WRITE is taken and timeout_err stays 0.
- start pulsed repeatedly while busy, and eng_ready pulsed during CLEAR/FIRE -> no state change and no extra write.
- rst=0 during WAIT of sample 1 layer 2 -> next cycle all outputs 0, count=0, state IDLE. A new start then runs a complete clean run.
